// File: rtl/word_packer_if.sv
// Byte-in / word-out handshake bundle for word_packer.
// master drives bytes, flush and out_ready; slave is the packer itself.
interface word_packer_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [31:0] out_data;
   logic [2:0]  out_bytes;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output in_data, in_valid, flush, out_ready,
      input  in_ready, out_data, out_bytes, out_valid
   );

   modport slave (
      input  in_data, in_valid, flush, out_ready,
      output in_ready, out_data, out_bytes, out_valid
   );
endinterface

// File: rtl/word_packer.sv
// Packs a byte stream big-endian into 32-bit words; flush emits a padded
// partial word with its byte count. The byte count doubles as the FSM state.
module word_packer #(
   parameter logic [7:0] PAD_BYTE = 8'h00
) (
   input logic          clk,
   input logic          reset,
   word_packer_if.slave bus
);

   typedef enum logic [1:0] {EMPTY, B1, B2, B3} cnt_e;

   cnt_e        cnt, cnt_next;
   logic [23:0] acc, acc_next;
   logic        flush_pend, flush_pend_next;
   logic [31:0] out_data, out_data_next;
   logic [2:0]  out_bytes, out_bytes_next;
   logic        out_valid, out_valid_next;

   logic        slot_free;
   logic        in_ready;
   logic        accept;
   logic [2:0]  k;
   logic [23:0] acc_ins;
   logic        emit;
   logic [31:0] word;
   logic [2:0]  word_bytes;

   // Keep the first n lanes of raw, replace the rest with PAD_BYTE.
   function automatic logic [31:0] pad_word(input logic [31:0] raw, input logic [2:0] n);
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 4; i++)
         w[31-8*i -: 8] = (3'(i) < n) ? raw[31-8*i -: 8] : PAD_BYTE;
      return w;
   endfunction

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      slot_free       = !out_valid || bus.out_ready;
      in_ready        = !flush_pend && (cnt != B3 || slot_free);
      accept          = bus.in_valid && in_ready;
      k               = {1'b0, cnt} + {2'b00, accept};
      acc_ins         = acc;
      cnt_next        = cnt;
      acc_next        = acc;
      flush_pend_next = flush_pend;
      out_data_next   = out_data;
      out_bytes_next  = out_bytes;
      out_valid_next  = out_valid && !bus.out_ready;
      emit            = 1'b0;
      word            = '0;
      word_bytes      = k;

      if (accept) begin
         case (cnt)
            EMPTY:   acc_ins[23:16] = bus.in_data;
            B1:      acc_ins[15:8]  = bus.in_data;
            B2:      acc_ins[7:0]   = bus.in_data;
            default: ;
         endcase
      end

      if (flush_pend) begin
         // in_ready is low here, so no byte arrives and any new flush is absorbed.
         if (slot_free) begin
            emit            = 1'b1;
            word            = pad_word({acc, PAD_BYTE}, {1'b0, cnt});
            word_bytes      = {1'b0, cnt};
            cnt_next        = EMPTY;
            flush_pend_next = 1'b0;
         end
      end else if (accept && cnt == B3) begin
         emit       = 1'b1;
         word       = {acc, bus.in_data};
         word_bytes = 3'd4;
         cnt_next   = EMPTY;
      end else if (bus.flush && k != 3'd0) begin
         if (slot_free) begin
            emit     = 1'b1;
            word     = pad_word({acc_ins, PAD_BYTE}, k);
            cnt_next = EMPTY;
         end else begin
            acc_next        = acc_ins;
            cnt_next        = cnt_e'(k[1:0]);
            flush_pend_next = 1'b1;
         end
      end else if (accept) begin
         acc_next = acc_ins;
         cnt_next = cnt_e'(k[1:0]);
      end

      if (emit) begin
         out_data_next  = word;
         out_bytes_next = word_bytes;
         out_valid_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every register update from pre-edge values, independent of statement order.
      if (reset) begin
         cnt        <= EMPTY;
         acc        <= '0;
         flush_pend <= 1'b0;
         out_data   <= '0;
         out_bytes  <= '0;
         out_valid  <= 1'b0;
      end else begin
         cnt        <= cnt_next;
         acc        <= acc_next;
         flush_pend <= flush_pend_next;
         out_data   <= out_data_next;
         out_bytes  <= out_bytes_next;
         out_valid  <= out_valid_next;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_data  = out_data;
   assign bus.out_bytes = out_bytes;
   assign bus.out_valid = out_valid;

endmodule
